input_capture_periph: RTL

- Memory-mapped input peripheral: the input-direction counterpart of the existing 7-bit output peripheral.
- Samples 4 external input pins (switches/buttons), synchronizes and debounces them, and latches rising/falling edges into sticky flags the CPU reads and clears.
- Drives a level interrupt request toward the core.
- Sits on the pipeline's data-memory bus next to the output peripheral; the address decoder supplies the enable and register select.

---
 rtl/input_capture_periph_pkg.sv | 21 ++
 rtl/input_capture_periph_if.sv | 22 ++
 rtl/input_capture_periph_debounce_bit.sv | 54 +++++
 rtl/input_capture_periph.sv | 75 +++++++
 4 files changed

// File: rtl/input_capture_periph_pkg.sv
// Shared constants for the input capture peripheral: register map and
// default debounce depth.
package input_capture_periph_pkg;

    localparam int NUM_IN_DEF          = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Register select decoded from the two low address bits
    typedef enum logic [1:0] {
        ADDR_STATE = 2'd0,
        ADDR_RISE  = 2'd1,
        ADDR_FALL  = 2'd2,
        ADDR_IEN   = 2'd3
    } reg_addr_e;

    // Width that can hold 0..cycles inclusive
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_capture_periph_if.sv
// Data-memory bus slice seen by the input capture peripheral: decoder select,
// write strobe, register select, write/read data and the interrupt line.
interface input_capture_periph_if #(
    parameter int NUM_IN = 4
);
    logic              SEL;
    logic              WE;
    logic [1:0]        ADDR;
    logic [NUM_IN-1:0] WriteData;
    logic [NUM_IN-1:0] ReadData;
    logic              IRQ;

    modport master (
        output SEL, WE, ADDR, WriteData,
        input  ReadData, IRQ
    );

    modport slave (
        input  SEL, WE, ADDR, WriteData,
        output ReadData, IRQ
    );
endinterface

// File: rtl/input_capture_periph_debounce_bit.sv
// One input pin: two-flop synchronizer followed by a counter debouncer.
// rise/fall are single-cycle pulses asserted on the edge where the accepted
// level changes, so the owner can latch them on that same edge.
module input_capture_periph_debounce_bit
    import input_capture_periph_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          s1;
    logic          s2;
    logic          stable_q;
    logic [CW-1:0] cnt;
    logic          accept;

    // The change is accepted on the edge where the count has already seen
    // DEBOUNCE_CYCLES-1 differing cycles and s2 still differs.
    assign accept = (s2 != stable_q) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Synchronize the pin, then count consecutive cycles away from the stable level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == stable_q) begin
                cnt <= '0;
            end else if (accept) begin
                stable_q <= s2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign stable = stable_q;
    assign rise   = accept &  s2;
    assign fall   = accept & ~s2;

endmodule

// File: rtl/input_capture_periph.sv
// Memory-mapped input capture peripheral: debounced pin levels, sticky
// write-1-to-clear edge flags, an interrupt enable mask and a level IRQ.
module input_capture_periph
    import input_capture_periph_pkg::*;
#(
    parameter int NUM_IN          = NUM_IN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_IN-1:0]     INPUTS,
    input_capture_periph_if.slave bus
);

    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] rise_p;
    logic [NUM_IN-1:0] fall_p;
    logic [NUM_IN-1:0] rise_q;
    logic [NUM_IN-1:0] fall_q;
    logic [NUM_IN-1:0] ien_q;
    logic [NUM_IN-1:0] clr_rise;
    logic [NUM_IN-1:0] clr_fall;
    logic              wr_en;
    logic [NUM_IN-1:0] rdata;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_bit
        input_capture_periph_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (INPUTS[g]),
            .stable (stable[g]),
            .rise   (rise_p[g]),
            .fall   (fall_p[g])
        );
    end

    assign wr_en    = bus.SEL & bus.WE;
    assign clr_rise = (wr_en && bus.ADDR == ADDR_RISE) ? bus.WriteData : '0;
    assign clr_fall = (wr_en && bus.ADDR == ADDR_FALL) ? bus.WriteData : '0;

    // Sticky edge flags (a set on the same edge as a clear wins) and the enable mask
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
            ien_q  <= '0;
        end else begin
            rise_q <= (rise_q & ~clr_rise) | rise_p;
            fall_q <= (fall_q & ~clr_fall) | fall_p;
            if (wr_en && bus.ADDR == ADDR_IEN) begin
                ien_q <= bus.WriteData;
            end
        end
    end

    // Combinational register read; an unselected peripheral drives zero
    always_comb begin
        rdata = '0;
        if (bus.SEL) begin
            case (bus.ADDR)
                ADDR_STATE: rdata = stable;
                ADDR_RISE:  rdata = rise_q;
                ADDR_FALL:  rdata = fall_q;
                ADDR_IEN:   rdata = ien_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.ReadData = rdata;
    assign bus.IRQ      = |((rise_q | fall_q) & ien_q);

endmodule
